inst_fetch: RTL

Program-counter and fetch stage sitting directly upstream of inst_memory. Drives the instruction address every cycle and tracks the single in-flight request across the memory's one-cycle registered read. Presents the returned instruction word and its PC to decode with a valid flag. Handles stall, branch/jump redirect, and the memory's out-of-range exception.

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/inst_fetch.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
//
// Shared definitions for the CPU front end: the fetch-stage state encoding,
// the per-cycle fetch action used to steer the PC datapath, and the default
// widths / reset vector that the fetch stage and inst_memory agree on.
// ----------------------------------------------------------------------------
package cpu_pkg;

   // Default widths; instances may override them through their parameters.
   localparam int DEF_INSTR_ADDR_WIDTH     = 16;
   localparam int DEF_INSTR_DATA_BIT_WIDTH = 16;

   // First address fetched after reset.
   localparam int DEF_RESET_PC = 0;

   // Width of the delivered-instruction counter and its saturation value.
   localparam int                    FETCH_COUNT_WIDTH = 16;
   localparam logic [FETCH_COUNT_WIDTH-1:0] FETCH_COUNT_MAX = 16'hFFFF;

   // Fetch-stage states.
   typedef enum logic [1:0] {
      FETCH_BOOT = 2'd0,
      FETCH_RUN  = 2'd1,
      FETCH_HALT = 2'd2
   } fetch_state_t;

   // What the PC datapath does on the coming clock edge. Decoded once in the
   // output process so that the state machine and datapath agree on priority.
   typedef enum logic [2:0] {
      ACT_HOLD     = 3'd0,
      ACT_BOOT     = 3'd1,
      ACT_ADVANCE  = 3'd2,
      ACT_REDIRECT = 3'd3,
      ACT_FAULT    = 3'd4
   } fetch_action_t;

endpackage : cpu_pkg

// File: rtl/inst_fetch.sv
// ----------------------------------------------------------------------------
// inst_fetch
//
// Program counter and fetch stage in front of inst_memory. It drives the
// instruction address every cycle, tracks the single request in flight across
// the memory's one-cycle registered read, and hands the returned word plus
// its address to decode with a valid flag. Handles stall, branch/jump
// redirect and the memory's out-of-range exception.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   stall          decode cannot accept; hold the current instruction
//   redirect_valid taken branch/jump this cycle
//   redirect_addr  redirect target
//   imem_addr      address to inst_memory (combinational)
//   imem_data      inst_memory read data (one-cycle latency)
//   imem_exc       inst_memory out-of-range flag, aligned with imem_data
//   inst_out       instruction to decode
//   pc_out         address of inst_out
//   inst_valid     inst_out / pc_out are valid
//   fetch_exc      sticky fetch fault flag
//   exc_addr       address that faulted
//   fetch_count    instructions delivered, saturating at 16'hFFFF
// ----------------------------------------------------------------------------
module inst_fetch
   import cpu_pkg::*;
#(
   parameter int INSTR_ADDR_WIDTH     = DEF_INSTR_ADDR_WIDTH,
   parameter int INSTR_DATA_BIT_WIDTH = DEF_INSTR_DATA_BIT_WIDTH,
   parameter int RESET_PC             = DEF_RESET_PC
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            stall,
   input  logic                            redirect_valid,
   input  logic [INSTR_ADDR_WIDTH-1:0]     redirect_addr,
   output logic [INSTR_ADDR_WIDTH-1:0]     imem_addr,
   input  logic [INSTR_DATA_BIT_WIDTH-1:0] imem_data,
   input  logic                            imem_exc,
   output logic [INSTR_DATA_BIT_WIDTH-1:0] inst_out,
   output logic [INSTR_ADDR_WIDTH-1:0]     pc_out,
   output logic                            inst_valid,
   output logic                            fetch_exc,
   output logic [INSTR_ADDR_WIDTH-1:0]     exc_addr,
   output logic [FETCH_COUNT_WIDTH-1:0]    fetch_count
);

   localparam logic [INSTR_ADDR_WIDTH-1:0] RESET_PC_W = INSTR_ADDR_WIDTH'(RESET_PC);
   localparam logic [INSTR_ADDR_WIDTH-1:0] ADDR_ONE   = INSTR_ADDR_WIDTH'(1);

   fetch_state_t                  state;
   fetch_state_t                  state_next;
   fetch_action_t                 action;

   logic [INSTR_ADDR_WIDTH-1:0]   pc;
   logic [INSTR_ADDR_WIDTH-1:0]   rsp_pc;
   logic                          rsp_live;
   logic                          exc_flag;
   logic [INSTR_ADDR_WIDTH-1:0]   exc_addr_q;
   logic [FETCH_COUNT_WIDTH-1:0]  count_q;
   logic                          word_ok;

   // State register. Reset always lands in BOOT, whatever else is asserted.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FETCH_BOOT;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. Redirect is the only way out of HALT; a returning
   // word flagged out-of-range sends RUN to HALT unless it is being squashed
   // by a redirect in the same cycle.
   always_comb begin
      state_next = state;
      unique case (state)
         FETCH_BOOT: state_next = FETCH_RUN;
         FETCH_RUN: begin
            if (redirect_valid) begin
               state_next = FETCH_RUN;
            end else if (rsp_live && imem_exc) begin
               state_next = FETCH_HALT;
            end
         end
         FETCH_HALT: begin
            if (redirect_valid) begin
               state_next = FETCH_RUN;
            end
         end
         default: state_next = FETCH_BOOT;
      endcase
   end

   // Output / action decode. word_ok says the word now on imem_data belongs
   // to a live request and is not faulted. The action priority is redirect,
   // then fault, then stall, then advance; a fault wins over stall so a
   // stalled decode cannot mask a bad fetch.
   always_comb begin
      word_ok = 1'b0;
      action  = ACT_HOLD;
      unique case (state)
         FETCH_BOOT: action = ACT_BOOT;
         FETCH_RUN: begin
            word_ok = rsp_live && !imem_exc;
            if (redirect_valid) begin
               action = ACT_REDIRECT;
            end else if (rsp_live && imem_exc) begin
               action = ACT_FAULT;
            end else if (stall) begin
               action = ACT_HOLD;
            end else begin
               action = ACT_ADVANCE;
            end
         end
         FETCH_HALT: begin
            if (redirect_valid) begin
               action = ACT_REDIRECT;
            end
         end
         default: action = ACT_HOLD;
      endcase
   end

   // Address to memory. During a stall the memory re-reads the address of
   // the word already being shown, so imem_data stays put without needing a
   // holding register here. HALT parks on pc and ignores stall.
   always_comb begin
      imem_addr = pc;
      if (rst || state == FETCH_BOOT) begin
         imem_addr = RESET_PC_W;
      end else if (redirect_valid) begin
         imem_addr = redirect_addr;
      end else if (state == FETCH_HALT) begin
         imem_addr = pc;
      end else if (stall) begin
         imem_addr = rsp_pc;
      end
   end

   // PC datapath and the fault / delivery bookkeeping. pc is the next
   // address to issue, rsp_pc the address whose data is arriving now, and
   // rsp_live marks that arriving data as not squashed. A fault leaves pc
   // untouched so the parked address is the one after the faulting word.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc         <= RESET_PC_W;
         rsp_pc     <= '0;
         rsp_live   <= 1'b0;
         exc_flag   <= 1'b0;
         exc_addr_q <= '0;
         count_q    <= '0;
      end else begin
         unique case (action)
            ACT_BOOT: begin
               pc       <= RESET_PC_W + ADDR_ONE;
               rsp_pc   <= RESET_PC_W;
               rsp_live <= 1'b1;
            end
            ACT_ADVANCE: begin
               pc       <= pc + ADDR_ONE;
               rsp_pc   <= pc;
               rsp_live <= 1'b1;
               if (word_ok && count_q != FETCH_COUNT_MAX) begin
                  count_q <= count_q + 1'b1;
               end
            end
            ACT_REDIRECT: begin
               pc       <= redirect_addr + ADDR_ONE;
               rsp_pc   <= redirect_addr;
               rsp_live <= 1'b1;
               exc_flag <= 1'b0;
            end
            ACT_FAULT: begin
               rsp_live   <= 1'b0;
               exc_flag   <= 1'b1;
               exc_addr_q <= rsp_pc;
            end
            default: begin
            end
         endcase
      end
   end

   // Decode-facing outputs, forced to zero while reset is held so nothing
   // downstream sees stale state during the reset cycle.
   always_comb begin
      inst_out    = '0;
      pc_out      = '0;
      inst_valid  = 1'b0;
      fetch_exc   = 1'b0;
      exc_addr    = '0;
      fetch_count = '0;
      if (!rst) begin
         inst_out    = imem_data;
         pc_out      = rsp_pc;
         inst_valid  = word_ok;
         fetch_exc   = exc_flag;
         exc_addr    = exc_addr_q;
         fetch_count = count_q;
      end
   end

endmodule : inst_fetch
